// File: rtl/modn_seq_pkg.sv
// Shared FSM encoding and legal-modulus bounds for the modn_seq counter.
package modn_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_RUN   = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int MOD_MIN = 2;

endpackage

// File: rtl/modn_core.sv
// Wrap counter 0..modv-1 with synchronous clear (priority) and enable.
module modn_core #(
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [CW-1:0] modv,
   output logic [CW-1:0] out,
   output logic          tc
);

   logic [CW-1:0] cnt;
   logic          wrap;

   assign wrap = (cnt == modv - CW'(1));
   assign tc   = en & wrap;
   assign out  = cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/modn_seq.sv
// Configurable modulo-N sequencer. Optional macro MODN_SEQ_PERIODS_EN adds
// the cfg_periods port, a programmed period count and the DONE state.
module modn_seq
   import modn_seq_pkg::*;
#(
   parameter  int NMAX = 17,
   parameter  int PW   = 8,
   localparam int CW   = (NMAX > 2) ? $clog2(NMAX) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [CW-1:0] cfg_mod,
`ifdef MODN_SEQ_PERIODS_EN
   input  logic [PW-1:0] cfg_periods,
`endif
   input  logic          start,
   input  logic          stop,
   input  logic          pause,
   output logic [CW-1:0] out,
   output logic          tc,
   output logic          busy,
   output logic          done,
   output logic          cfg_err
);

   state_t        state, nxt;
   logic [CW-1:0] m_q;
   logic [PW-1:0] per_q;
   logic [PW-1:0] pcnt;
   logic [PW-1:0] pcnt_nxt;
   logic          cfg_ok;
   logic          ld_cfg, err_nxt, pcnt_clr, pcnt_inc;
   logic          core_clr, core_en, core_tc;

   function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v);
      return (&v) ? v : v + PW'(1);
   endfunction

   assign cfg_ok    = (int'(cfg_mod) >= MOD_MIN) && (int'(cfg_mod) <= NMAX);
   assign pcnt_nxt  = sat_inc(pcnt);
   assign cfg_ready = (state == S_IDLE) || (state == S_ARMED);
   assign busy      = (state == S_RUN) || (state == S_HOLD);
   assign tc        = core_tc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         m_q     <= '0;
         cfg_err <= 1'b0;
         pcnt    <= '0;
      end else begin
         state   <= nxt;
         cfg_err <= err_nxt;
         if (ld_cfg) m_q <= cfg_mod;
         if (pcnt_clr)      pcnt <= '0;
         else if (pcnt_inc) pcnt <= pcnt_nxt;
      end
   end

`ifdef MODN_SEQ_PERIODS_EN
   always_ff @(posedge clk) begin
      if (rst)         per_q <= '0;
      else if (ld_cfg) per_q <= cfg_periods;
   end
   assign done = (state == S_DONE);
`else
   assign per_q = '0;
   assign done  = 1'b0;
`endif

   // Handshake outranks start; stop outranks pause; the counter keeps its
   // enable during stop so a coincident tc is still visible.
   always_comb begin
      nxt      = state;
      ld_cfg   = 1'b0;
      err_nxt  = 1'b0;
      pcnt_clr = 1'b0;
      pcnt_inc = 1'b0;
      core_clr = 1'b0;
      core_en  = 1'b0;
      case (state)
         S_IDLE, S_ARMED: begin
            if (cfg_valid) begin
               if (cfg_ok) begin
                  ld_cfg = 1'b1;
                  nxt    = S_ARMED;
               end else begin
                  err_nxt = 1'b1;
               end
            end else if (start && state == S_ARMED) begin
               nxt      = S_RUN;
               core_clr = 1'b1;
               pcnt_clr = 1'b1;
            end
         end
         S_RUN: begin
            core_en = !pause;
            if (stop) begin
               nxt      = S_ARMED;
               core_clr = 1'b1;
            end else if (pause) begin
               nxt = S_HOLD;
            end else if (core_tc) begin
               pcnt_inc = 1'b1;
               if (per_q != '0 && pcnt_nxt == per_q) nxt = S_DONE;
            end
         end
         S_HOLD: begin
            if (stop) begin
               nxt      = S_ARMED;
               core_clr = 1'b1;
            end else if (!pause) begin
               nxt = S_RUN;
            end
         end
         S_DONE:  nxt = S_ARMED;
         default: nxt = S_IDLE;
      endcase
   end

   modn_core #(.CW(CW)) u_core (
      .clk  (clk),
      .rst  (rst),
      .clr  (core_clr),
      .en   (core_en),
      .modv (m_q),
      .out  (out),
      .tc   (core_tc)
   );

endmodule

// File: tb/tb_modn_seq.sv
// Directed bench for modn_seq with hand-computed expectations (NMAX=17, PW=8).
module tb_modn_seq;

   logic       clk = 1'b0;
   logic       rst, cfg_valid, start, stop, pause;
   logic [4:0] cfg_mod;
`ifdef MODN_SEQ_PERIODS_EN
   logic [7:0] cfg_periods;
`endif
   logic       cfg_ready, tc, busy, done, cfg_err;
   logic [4:0] out;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   modn_seq #(.NMAX(17), .PW(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_mod     (cfg_mod),
`ifdef MODN_SEQ_PERIODS_EN
      .cfg_periods (cfg_periods),
`endif
      .start       (start),
      .stop        (stop),
      .pause       (pause),
      .out         (out),
      .tc          (tc),
      .busy        (busy),
      .done        (done),
      .cfg_err     (cfg_err)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int m, input int p);
      cfg_valid = 1'b1;
      cfg_mod   = 5'(m);
`ifdef MODN_SEQ_PERIODS_EN
      cfg_periods = 8'(p);
`else
      if (p != 0) $display("note: periods ignored in this build");
`endif
      cyc();
      cfg_valid = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
      cfg_mod = '0;
`ifdef MODN_SEQ_PERIODS_EN
      cfg_periods = '0;
`endif
      cyc(); cyc();
      rst = 1'b0;
      #2;
      chk("rst_out", out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", cfg_err, 0);
      chk("rst_ready", cfg_ready, 1);
      chk("rst_tc", tc, 0);

      // Illegal moduli are rejected and leave the block in IDLE
      cfg(1, 0);
      chk("err1_pulse", cfg_err, 1);
      chk("err1_ready", cfg_ready, 1);
      cyc();
      chk("err1_clear", cfg_err, 0);
      cfg(18, 0);
      chk("err18_pulse", cfg_err, 1);
      cyc();
      chk("err18_clear", cfg_err, 0);
      go();
      chk("idle_start_busy", busy, 0);
      cyc();
      chk("idle_start_out", out, 0);
      chk("idle_start_busy2", busy, 0);

      // M=5 counting; with periods=2 the run ends in DONE
      cfg(5, 2);
      chk("armed_ready", cfg_ready, 1);
      go();
`ifdef MODN_SEQ_PERIODS_EN
      for (int i = 0; i < 10; i++) begin
         chk("m5_out", out, i % 5);
         chk("m5_tc", tc, (i % 5 == 4) ? 1 : 0);
         chk("m5_done", done, 0);
         chk("m5_busy", busy, 1);
         cyc();
      end
      chk("m5_done_pulse", done, 1);
      chk("m5_done_out", out, 0);
      chk("m5_done_busy", busy, 0);
      chk("m5_done_ready", cfg_ready, 0);
      cyc();
      chk("m5_after_done", done, 0);
      chk("m5_after_ready", cfg_ready, 1);
      chk("m5_after_busy", busy, 0);
`else
      for (int i = 0; i < 12; i++) begin
         chk("m5_out", out, i % 5);
         chk("m5_tc", tc, (i % 5 == 4) ? 1 : 0);
         chk("m5_done", done, 0);
         cyc();
      end
      stop = 1'b1; cyc(); stop = 1'b0;
      chk("m5_stop_ready", cfg_ready, 1);
`endif

      // M=4 free-run, pause at out=2 for three cycles
      cfg(4, 0);
      go();
      chk("p_out0", out, 0);
      cyc();
      chk("p_out1", out, 1);
      cyc();
      pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("p_hold_out", out, 2);
         chk("p_hold_tc", tc, 0);
         chk("p_hold_busy", busy, 1);
         cyc();
      end
      pause = 1'b0;
      chk("p_release_out", out, 2);
      chk("p_release_busy", busy, 1);
      cyc();
      chk("p_resume_out", out, 2);
      cyc();
      chk("p_at3_out", out, 3);
      chk("p_at3_tc", tc, 1);
      cyc();
      chk("p_wrap_out", out, 0);
      stop = 1'b1; cyc(); stop = 1'b0;

      // M=3, stop coincident with tc
      cfg(3, 0);
      go();
      cyc(); cyc();
      chk("s_out2", out, 2);
      stop = 1'b1;
      #1;
      chk("s_tc", tc, 1);
      chk("s_done_now", done, 0);
      cyc();
      stop = 1'b0;
      chk("s_out", out, 0);
      chk("s_busy", busy, 0);
      chk("s_done", done, 0);
      chk("s_ready", cfg_ready, 1);

      // Handshake beats start in ARMED; new M=6 is used by the next run
      cfg_valid = 1'b1; cfg_mod = 5'd6; start = 1'b1;
      cyc();
      cfg_valid = 1'b0; start = 1'b0;
      chk("hs_busy", busy, 0);
      chk("hs_ready", cfg_ready, 1);
      go();
      for (int i = 0; i < 8; i++) begin
         chk("m6_out", out, i % 6);
         chk("m6_tc", tc, (i % 6 == 5) ? 1 : 0);
         cyc();
      end

      // Reset mid-run at out=7 with M=10
      stop = 1'b1; cyc(); stop = 1'b0;
      cfg(10, 0);
      go();
      for (int i = 0; i < 7; i++) cyc();
      chk("r_out7", out, 7);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("r_out", out, 0);
      chk("r_busy", busy, 0);
      chk("r_ready", cfg_ready, 1);
      chk("r_done", done, 0);
      go();
      chk("r_start_busy", busy, 0);
      cyc();
      chk("r_start_out", out, 0);
      chk("r_start_busy2", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
